// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU opcodes, default latencies and FSM state type
package mdu_defs;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Ops that occupy the unit for a multi-cycle busy window.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// rtl/e_mdu_arith.sv - combinational multiply/divide datapath producing pending HI/LO
module mdu_arith
    import mdu_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_pend,
    output logic [31:0] lo_pend
);

    logic signed [63:0] s_rs_ext;
    logic signed [63:0] s_rt_ext;
    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic signed [31:0] s_rs;
    logic signed [31:0] s_rt;

    assign s_rs     = rs;
    assign s_rt     = rt;
    assign s_rs_ext = {{32{rs[31]}}, rs};
    assign s_rt_ext = {{32{rt[31]}}, rt};
    assign s_prod   = s_rs_ext * s_rt_ext;
    assign u_prod   = {32'h0, rs} * {32'h0, rt};

    // Select the pending result; divide by zero keeps HI/LO, and the signed
    // overflow case is pinned so it never depends on simulator overflow rules.
    always_comb begin
        hi_pend = hi;
        lo_pend = lo;
        case (op)
            MDU_MULT: begin
                hi_pend = s_prod[63:32];
                lo_pend = s_prod[31:0];
            end
            MDU_MULTU: begin
                hi_pend = u_prod[63:32];
                lo_pend = u_prod[31:0];
            end
            MDU_DIV: begin
                if (rt == 32'h0) begin
                    hi_pend = hi;
                    lo_pend = lo;
                end else if ((rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF)) begin
                    hi_pend = 32'h0;
                    lo_pend = 32'h8000_0000;
                end else begin
                    lo_pend = s_rs / s_rt;
                    hi_pend = s_rs % s_rt;
                end
            end
            MDU_DIVU: begin
                if (rt == 32'h0) begin
                    hi_pend = hi;
                    lo_pend = lo;
                end else begin
                    lo_pend = rs / rt;
                    hi_pend = rs % rt;
                end
            end
            default: begin
                hi_pend = hi;
                lo_pend = lo;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO with a busy countdown
module e_mdu
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t         state;
    mdu_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_pend_q;
    logic [31:0]        lo_pend_q;
    logic [31:0]        hi_pend_d;
    logic [31:0]        lo_pend_d;
    logic               accept;
    logic               long_accept;
    logic               commit;

    assign busy        = (state == ST_BUSY);
    assign accept      = start & ~req & ~busy;
    assign long_accept = accept & is_long_op(mdu_op);

    mdu_arith u_arith (
        .op      (mdu_op),
        .rs      (rs),
        .rt      (rt),
        .hi      (hi),
        .lo      (lo),
        .hi_pend (hi_pend_d),
        .lo_pend (lo_pend_d)
    );

    // State register for the IDLE/BUSY sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enter BUSY on a long-op accept; leave on the edge the counter hits zero.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (long_accept) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Busy-window counter: load latency on accept, count down while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (long_accept) begin
            cnt <= is_div_op(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Hold the computed result until the busy window ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_pend_q <= 32'h0;
            lo_pend_q <= 32'h0;
        end else if (long_accept) begin
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    // Architectural HI/LO: written by commit or by an accepted mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (commit) begin
            hi <= hi_pend_q;
            lo <= lo_pend_q;
        end else if (accept && (mdu_op == MDU_MTHI)) begin
            hi <= rs;
        end else if (accept && (mdu_op == MDU_MTLO)) begin
            lo <= rs;
        end
    end

    // Move-from result into the E-stage result mux.
    always_comb begin
        mf_out = 32'h0;
        if (mdu_op == MDU_MFHI) begin
            mf_out = hi;
        end else if (mdu_op == MDU_MFLO) begin
            mf_out = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - randomized self-checking bench for e_mdu against an arithmetic model
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .start  (start),
        .mdu_op (mdu_op),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mf_out (mf_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product: 64-bit arithmetic on extended operands.
    function automatic logic [63:0] ref_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    // Reference divide via magnitudes and sign fix-up; div by zero keeps HI/LO.
    task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] uq;
        logic [31:0] ur;
        if (b == 0) begin
            q = m_lo;
            r = m_hi;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            ma = a[31] ? (32'h0 - a) : a;
            mb = b[31] ? (32'h0 - b) : b;
            uq = ma / mb;
            ur = ma % mb;
            q  = (a[31] ^ b[31]) ? (32'h0 - uq) : uq;
            r  = a[31] ? (32'h0 - ur) : ur;
        end
    endtask

    // Issue one op for one cycle and check timing/results against the model.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rq);
        logic [63:0] p;
        logic [31:0] n_hi;
        logic [31:0] n_lo;
        int          n;
        bit          accepted;
        accepted = !rq;
        n_hi = m_hi;
        n_lo = m_lo;
        n    = 0;
        start = 1'b1; mdu_op = op; rs = a; rt = b; req = rq;
        #1;
        chk({tag, "_mf"}, mf_out, (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'h0);
        if (accepted) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    p = ref_mult(op == OP_MULT, a, b);
                    n_hi = p[63:32]; n_lo = p[31:0]; n = MC;
                end
                OP_DIV, OP_DIVU: begin
                    ref_div(op == OP_DIV, a, b, n_lo, n_hi); n = DC;
                end
                OP_MTHI: n_hi = a;
                OP_MTLO: n_lo = a;
                default: ;
            endcase
        end
        step();
        start = 1'b0; req = 1'b0; mdu_op = OP_NONE;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), {31'h0, busy}, 32'h1);
            if (k == n - 1) chk({tag, "_hold_hi"}, hi, m_hi);
            step();
        end
        m_hi = n_hi;
        m_lo = n_lo;
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; mdu_op = OP_NONE; rs = 0; rt = 0;
        m_hi = 0; m_lo = 0;
        step(); step();
        reset = 1'b0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        do_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo, 32'hFFFF_FFFE);
        do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_k", hi, 32'h1);
        chk("multu_lo_k", lo, 32'hFFFF_FFFE);

        do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_k", lo, 32'hFFFF_FFFD);
        chk("div_hi_k", hi, 32'hFFFF_FFFF);
        do_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("divu_lo_k", lo, 32'h7FFF_FFFC);
        chk("divu_hi_k", hi, 32'h1);

        do_op("mthi11", OP_MTHI, 32'h11, 0, 1'b0);
        do_op("mtlo22", OP_MTLO, 32'h22, 0, 1'b0);
        do_op("div0", OP_DIV, 32'h1234, 32'h0, 1'b0);
        chk("div0_hi_k", hi, 32'h11);
        chk("div0_lo_k", lo, 32'h22);
        do_op("divu0", OP_DIVU, 32'h1234, 32'h0, 1'b0);
        do_op("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_k", lo, 32'h8000_0000);
        chk("ovf_hi_k", hi, 32'h0);

        do_op("mthi_req", OP_MTHI, 32'hABCD, 0, 1'b1);
        do_op("mthi", OP_MTHI, 32'hABCD, 0, 1'b0);
        chk("mthi_k", hi, 32'hABCD);
        do_op("mfhi", OP_MFHI, 0, 0, 1'b0);
        do_op("mflo", OP_MFLO, 0, 0, 1'b0);
        do_op("none", OP_NONE, 32'h5555, 32'h7777, 1'b0);
        do_op("mult_req", OP_MULT, 32'h3, 32'h4, 1'b1);

        // req + MTLO during a mult, then a plain second start while busy.
        start = 1'b1; mdu_op = OP_MULT; rs = 32'h0001_0003; rt = 32'h0002_0005;
        step();
        start = 1'b0; mdu_op = OP_NONE;
        chk("fl_busy1", {31'h0, busy}, 32'h1);
        step();
        start = 1'b1; req = 1'b1; mdu_op = OP_MTLO; rs = 32'hDEAD_BEEF;
        chk("fl_busy2", {31'h0, busy}, 32'h1);
        step();
        req = 1'b0; mdu_op = OP_DIVU; rs = 32'h9; rt = 32'h2;
        chk("fl_busy3", {31'h0, busy}, 32'h1);
        step();
        start = 1'b0; mdu_op = OP_NONE;
        chk("fl_busy4", {31'h0, busy}, 32'h1);
        chk("fl_lo_mid", lo, m_lo);
        step();
        chk("fl_busy5", {31'h0, busy}, 32'h1);
        step();
        chk("fl_done", {31'h0, busy}, 32'h0);
        chk("fl_hi", hi, 32'h2);
        chk("fl_lo", lo, 32'h000B_000F);
        m_hi = 32'h2; m_lo = 32'h000B_000F;
        step(); step();
        chk("fl_no_second", {31'h0, busy}, 32'h0);
        chk("fl_lo_after", lo, 32'h000B_000F);

        // Reset in the middle of a divide aborts it.
        start = 1'b1; mdu_op = OP_DIVU; rs = 32'd100; rt = 32'd7;
        step();
        start = 1'b0; mdu_op = OP_NONE;
        step(); step();
        chk("rb_busy3", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rb_busy", {31'h0, busy}, 32'h0);
        chk("rb_hi", hi, 32'h0);
        chk("rb_lo", lo, 32'h0);
        m_hi = 0; m_lo = 0;
        for (int k = 0; k < DC + 2; k++) step();
        chk("rb_nocommit_busy", {31'h0, busy}, 32'h0);
        chk("rb_nocommit_hi", hi, 32'h0);
        chk("rb_nocommit_lo", lo, 32'h0);

        for (int i = 0; i < 60; i++) begin
            do_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 8)), rand_val(), rand_val(),
                  ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
